// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and resp_err bit positions.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_ILLEGAL  = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } lsu_state_t;

    // Stores only support b/h/w; loads reject the three unassigned codes.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        else
            return (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
    endfunction

    function automatic logic f3_is_half(input logic [2:0] f3);
        return (f3 == F3_H || f3 == F3_HU);
    endfunction

    function automatic logic f3_is_word(input logic [2:0] f3);
        return (f3 == F3_W);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic shared by the load path (extract + extend) and
// the sub-word store path (merge new byte/half into the old word).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merge
);

    logic [31:0] w_shift;

    always_comb begin
        w_shift = i_word >> {i_off, 3'b000};
        case (i_funct3)
            F3_B:    o_load = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_H:    o_load = {{16{w_shift[15]}}, w_shift[15:0]};
            F3_BU:   o_load = {24'h0, w_shift[7:0]};
            F3_HU:   o_load = {16'h0, w_shift[15:0]};
            default: o_load = i_word;
        endcase
    end

    always_comb begin
        o_merge = i_word;
        case (i_funct3)
            F3_B: o_merge[{i_off, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: begin
                if (i_off[1])
                    o_merge[31:16] = i_wdata[15:0];
                else
                    o_merge[15:0] = i_wdata[15:0];
            end
            default: o_merge = i_wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between MEM stage and a word-addressed data memory.
// Optional: LSU_MISALIGN_TRAP_EN reports misaligned accesses as errors;
// without it the offending low address bits are cleared and the access proceeds.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [2:0]  resp_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    input  logic [31:0] mem_rd
);

    lsu_state_t  r_state;
    lsu_state_t  w_next;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;
    logic [2:0]  r_err;

    logic        w_half;
    logic        w_word;
    logic        w_misalign;
    logic [31:0] w_addr_eff;
    logic [2:0]  w_err;
    logic [31:0] w_align_word;
    logic [31:0] w_load;
    logic [31:0] w_merge;
    logic        w_we_raw;

    always_comb begin
        w_half = f3_is_half(req_funct3);
        w_word = f3_is_word(req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        w_misalign = (w_half && req_addr[0]) || (w_word && (req_addr[1:0] != 2'b00));
        w_addr_eff = req_addr;
`else
        w_misalign = 1'b0;
        if (w_word)
            w_addr_eff = {req_addr[31:2], 2'b00};
        else if (w_half)
            w_addr_eff = {req_addr[31:1], 1'b0};
        else
            w_addr_eff = req_addr;
`endif
        w_err               = 3'b000;
        w_err[ERR_MISALIGN] = w_misalign;
        w_err[ERR_RANGE]    = ({2'b00, w_addr_eff[31:2]} >= 32'(MEM_WORDS));
        w_err[ERR_ILLEGAL]  = f3_illegal(req_we, req_funct3);
    end

    // The RMW write cycle merges into the word captured during ACCESS.
    assign w_align_word = (r_state == S_WRITE) ? r_merge : mem_rd;

    lsu_align u_align (
        .i_word   (w_align_word),
        .i_off    (r_addr[1:0]),
        .i_funct3 (r_f3),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merge  (w_merge)
    );

    always_comb begin
        w_next   = r_state;
        w_we_raw = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid)
                    w_next = (w_err != 3'b000) ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                if (r_we && (r_f3 == F3_W)) begin
                    w_we_raw = 1'b1;
                    w_next   = S_RESP;
                end else if (r_we) begin
                    w_next = S_WRITE;
                end else begin
                    w_next = S_RESP;
                end
            end
            S_WRITE: begin
                w_we_raw = 1'b1;
                w_next   = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_merge <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 3'b000;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_f3    <= req_funct3;
                        r_addr  <= w_addr_eff;
                        r_wdata <= req_wdata;
                        r_rdata <= 32'h0;
                        r_err   <= w_err;
                    end
                end
                S_ACCESS: begin
                    if (!r_we)
                        r_rdata <= w_load;
                    else if (r_f3 != F3_W)
                        r_merge <= mem_rd;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign mem_a      = {2'b00, r_addr[31:2]};
    assign mem_wd     = (r_state == S_WRITE) ? w_merge : r_wdata;
    // Gating with reset guarantees no write lands on or after a reset edge.
    assign mem_we     = w_we_raw & rst;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions against a byte-level reference model of the memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_err;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    logic [31:0] mem     [0:31];
    logic [31:0] ref_mem [0:31];

    int vecs = 0;
    int miscompares = 0;

    logic [31:0] last_wa;
    logic [31:0] last_wd;
    logic [31:0] got_rdata;
    logic [2:0]  got_err;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_we     (mem_we),
        .mem_rd     (mem_rd)
    );

    always @(posedge clk) begin
        if (mem_we && mem_a < 32)
            mem[mem_a[4:0]] <= mem_wd;
    end

    assign mem_rd = (mem_a < 32) ? mem[mem_a[4:0]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed semantics computed with plain arithmetic.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [2:0] err,
                         output logic [31:0] rdata, output int lat, output int nwr);
        logic        half;
        logic        word;
        logic [31:0] a;
        logic [31:0] w;
        logic [31:0] lane;
        logic [31:0] mask;
        int          idx;
        int          sh;
        half  = (f3 == 3'd1 || f3 == 3'd5);
        word  = (f3 == 3'd2);
        a     = addr;
        err   = 3'b000;
        rdata = 32'h0;
        nwr   = 0;
        lat   = 1;
        if (we) err[2] = (f3 > 3'd2);
        else    err[2] = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((half && a % 2 != 0) || (word && a % 4 != 0)) err[0] = 1'b1;
`else
        if (half) a = a - (a % 2);
        if (word) a = a - (a % 4);
`endif
        if (a / 4 >= 32) err[1] = 1'b1;
        if (err != 3'b000) return;
        idx  = int'(a / 4);
        sh   = 8 * int'(a % 4);
        w    = ref_mem[idx];
        lane = w >> sh;
        if (!we) begin
            lat = 2;
            case (f3)
                3'd0: begin rdata = lane % 256;   if (rdata >= 128)   rdata = rdata - 32'd256; end
                3'd1: begin rdata = lane % 65536; if (rdata >= 32768) rdata = rdata - 32'd65536; end
                3'd4: rdata = lane % 256;
                3'd5: rdata = lane % 65536;
                default: rdata = w;
            endcase
        end else begin
            nwr = 1;
            if (f3 == 3'd2) begin
                lat = 2;
                ref_mem[idx] = wdata;
            end else begin
                lat  = 3;
                mask = (f3 == 3'd0) ? (32'hFF << sh) : (32'hFFFF << sh);
                ref_mem[idx] = (w & ~mask) | ((wdata << sh) & mask);
            end
        end
    endtask

    task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [2:0]  e_err;
        logic [31:0] e_rdata;
        int          e_lat;
        int          e_nwr;
        int          n;
        int          nwr;
        int          wcyc;
        logic        got;
        model(we, f3, addr, wdata, e_err, e_rdata, e_lat, e_nwr);
        @(negedge clk);
        check({tag, ".ready"}, {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Scramble request inputs: the DUT must only use its registered copy.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        n    = 0;
        nwr  = 0;
        wcyc = 0;
        got  = 1'b0;
        while (n < 8 && !got) begin
            @(negedge clk);
            n++;
            if (mem_we) begin
                nwr++;
                wcyc    = n;
                last_wa = mem_a;
                last_wd = mem_wd;
            end
            if (resp_valid) got = 1'b1;
        end
        got_rdata = resp_rdata;
        got_err   = resp_err;
        check({tag, ".latency"}, 32'(n), 32'(e_lat));
        check({tag, ".rdata"}, resp_rdata, e_rdata);
        check({tag, ".err"}, {29'h0, resp_err}, {29'h0, e_err});
        check({tag, ".writes"}, 32'(nwr), 32'(e_nwr));
        if (e_nwr != 0) check({tag, ".wcycle"}, 32'(wcyc), 32'(e_lat - 1));
        @(negedge clk);
        check({tag, ".pulse"}, {31'h0, resp_valid}, 32'h0);
        check({tag, ".hold"}, resp_rdata, e_rdata);
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        last_wa    = 32'h0;
        last_wd    = 32'h0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        mem[2] = 32'h11223344;
        mem[3] = 32'h8899AABB;
        mem[5] = 32'hCAFEF00D;
        for (int i = 0; i < 32; i++) ref_mem[i] = mem[i];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.ready", {31'h0, req_ready}, 32'h1);
        check("reset.valid", {31'h0, resp_valid}, 32'h0);
        check("reset.rdata", resp_rdata, 32'h0);
        check("reset.err", {29'h0, resp_err}, 32'h0);
        check("reset.we", {31'h0, mem_we}, 32'h0);
        rst = 1'b1;

        do_txn("lb_0d", 1'b0, 3'b000, 32'h0D, 32'h0);
        check("lb_0d.const", got_rdata, 32'hFFFFFFAA);
        do_txn("lbu_0d", 1'b0, 3'b100, 32'h0D, 32'h0);
        check("lbu_0d.const", got_rdata, 32'h000000AA);
        do_txn("lh_0e", 1'b0, 3'b001, 32'h0E, 32'h0);
        check("lh_0e.const", got_rdata, 32'hFFFF8899);

        do_txn("sb_09", 1'b1, 3'b000, 32'h09, 32'h55);
        check("sb_09.mem_a", last_wa, 32'd2);
        check("sb_09.mem_wd", last_wd, 32'h11225544);
        do_txn("lw_08", 1'b0, 3'b010, 32'h08, 32'h0);
        check("lw_08.const", got_rdata, 32'h11225544);

        do_txn("sw_10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        check("sw_10.mem_wd", last_wd, 32'hDEADBEEF);

        do_txn("lw_06", 1'b0, 3'b010, 32'h06, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        check("lw_06.const", {29'h0, got_err}, 32'h1);
`else
        check("lw_06.const", got_rdata, mem[1]);
`endif
        do_txn("lw_80", 1'b0, 3'b010, 32'h80, 32'h0);
        check("lw_80.const", {29'h0, got_err}, 32'h2);
        do_txn("ld_f3_011", 1'b0, 3'b011, 32'h04, 32'h0);
        check("ld_f3_011.const", {29'h0, got_err}, 32'h4);

        // sh abandoned by reset during its WRITE cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h16;
        req_wdata  = 32'h00001234;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid.we_before", {31'h0, mem_we}, 32'h1);
        rst = 1'b0;
        #1;
        check("rst_mid.we_gated", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid.ready", {31'h0, req_ready}, 32'h1);
        begin
            int seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (resp_valid) seen++;
            end
            check("rst_mid.no_resp", 32'(seen), 32'h0);
        end
        check("rst_mid.mem", mem[5], 32'hCAFEF00D);

        for (int t = 0; t < 80; t++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            we   = 1'($urandom);
            f3   = 3'($urandom);
            addr = (32'($urandom_range(0, 35)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) addr[31] = 1'b1;
            do_txn($sformatf("rand%0d", t), we, f3, addr, $urandom);
        end

        for (int i = 0; i < 32; i++)
            check($sformatf("mem%0d", i), mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and the word-addressed 32-bit data memory.
- Converts RV32I byte-addressed load/store requests (lb/lh/lw/lbu/lhu/sb/sh/sw) into word accesses.
- Performs sign/zero extension on loads and read-modify-write for sub-word stores.
- Uses a valid/ready request and a one-cycle response pulse, so the pipeline stalls while an access is in flight.

Parameters:
- MEM_WORDS, 32: number of 32-bit words in the data memory; word index must be < MEM_WORDS.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 size/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; response fields valid.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  3  bit0 misaligned, bit1 out-of-range, bit2 illegal funct3.
- mem_a  out  32  word index to memory (byte address >> 2).
- mem_wd  out  32  write data to memory.
- mem_we  out  1  memory write enable.
- mem_rd  in  32  combinational memory read data.

Behaviour:
- Reset, sampled on posedge when rst==0:
  - state=IDLE; resp_valid=0, resp_rdata=0, resp_err=0, all internal registers 0.
  - mem_we is combinationally gated with rst, so it is never high while rst==0.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid&&req_ready and register we, funct3, addr, wdata.
  - Error checks at accept:
    - illegal funct3: load 011/110/111; store any code other than 000/001/010.
    - misaligned: half with addr[0]!=0; word with addr[1:0]!=0.
    - out-of-range: addr[31:2] >= MEM_WORDS.
  - Any error → RESP with resp_err set, resp_rdata=0, no memory activity. Otherwise → ACCESS.
- ACCESS: mem_a = registered addr[31:2].
  - Load: capture mem_rd, select byte/half by addr[1:0], sign-extend (lb/lh) or zero-extend (lbu/lhu), register into resp_rdata → RESP.
  - sw: mem_we=1, mem_wd=wdata → RESP.
  - sb/sh: register mem_rd into merge word → WRITE.
- WRITE: mem_we=1; mem_wd = merge word with the addressed byte/half replaced by wdata[7:0]/[15:0] → RESP.
- RESP: resp_valid=1 for exactly one cycle → IDLE. resp_rdata/resp_err are held until the next accept.
- Latency, from the accept edge to the resp_valid cycle: errors 1 cycle; loads and sw 2 cycles; sb/sh 3 cycles. Back-to-back throughput: next accept is possible in the cycle after RESP.
- mem_we is high only in a sw ACCESS cycle or a WRITE cycle, never on loads or errors.
- req_* may change while the LSU is busy; only the registered copies are used.
- Reset asserted mid-operation: the access is abandoned, no write occurs on or after the reset edge, and no response is produced.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests set resp_err[0] and do not touch memory, as above.
- Undefined: misalignment is never flagged (resp_err[0] is constant 0). Offending low address bits are cleared: addr[0] for half accesses, addr[1:0] for word accesses. The access then proceeds as aligned.

Decomposition:
- Package lsu_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state encoding.
  - resp_err bit indices: ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL.
- Sub-module lsu_align: purely combinational. Inputs are a word, offset and funct3. It produces the extended load value and the merged store word. It is reused by load and RMW paths.

Test Plan:
- mem[3]=0x8899AABB; lb addr 0x0D → resp_rdata=0xFFFFFFAA two cycles after accept; lbu same → 0x000000AA; lh addr 0x0E → 0xFFFF8899.
- mem[2]=0x11223344; sb addr 0x09 wdata 0x55 → one mem_we pulse in WRITE with mem_a=2, mem_wd=0x11225544; a following lw 0x08 returns 0x11225544.
- sw addr 0x10 wdata 0xDEADBEEF → mem_we in ACCESS, resp_valid next cycle, resp_err=0.
- With LSU_MISALIGN_TRAP_EN defined: lw addr 0x06 → resp_err=3'b001 one cycle after accept, mem_we never high. Undefined: same request reads mem[1].
- lw addr 0x80 (index 32) → resp_err=3'b010. Load funct3=3'b011 → resp_err=3'b100.
- sh in flight, rst=0 during WRITE cycle → mem_we=0 that cycle, no resp_valid, req_ready=1 after release; memory word unchanged.
